dmem_port_arbiter: RTL

- Shares one BRAM data-memory port between NUM_REQ load/store requesters (per-thread LSUs of a core) using a work-conserving round-robin policy.
- Accepts requests with a valid/ready handshake and drives the BRAM port combinationally in the grant cycle.
- Tracks in-flight reads through a grant-index shift pipeline and returns registered read data to the originating requester.
- Provides optional per-requester thread-local address partitioning and a flush/drain FSM used by the dispatcher before core reset.

---
 rtl/dmem_port_arbiter_pkg.sv | 18 +
 rtl/dmem_port_arbiter_rr_grant.sv | 34 +++
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared data-memory types, thread-local partition constants and arbiter FSM states.
// Pure declarations, no logic.
package dmem_port_arbiter_pkg;

  typedef logic [31:0] data_memory_address_t;
  typedef logic [31:0] data_t;

  localparam int DATA_MEMORY_WE_WIDTH = 4;
  localparam data_memory_address_t THREAD_LOCAL_MEM_BASE_ADDR = 32'h0000_8000;
  localparam int THREAD_LOCAL_MEM_PARTITION_SIZE_WORDS = 256;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FLUSHED
  } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_grant.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping modulo N.
// Zero latency; no backpressure of its own.
module dmem_port_arbiter_rr_grant
  import dmem_port_arbiter_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          grant_valid
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the far end back toward ptr so the closest requester overwrites the rest.
  always_comb begin
    winner      = '0;
    grant_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        winner      = wrap_add(ptr, k);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin share of one BRAM port between NUM_REQ LSUs; grant drives the port in the same cycle.
// Read data returns READ_LATENCY+1 cycles after grant and cannot be back-pressured; flush FSM drains reads.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int                    NUM_REQ         = 16,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    WE_WIDTH        = DATA_MEMORY_WE_WIDTH,
  parameter int                    READ_LATENCY    = 1,
  parameter bit                    PARTITION_EN    = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] PARTITION_BASE  = ADDR_WIDTH'(THREAD_LOCAL_MEM_BASE_ADDR),
  parameter int                    PARTITION_WORDS = THREAD_LOCAL_MEM_PARTITION_SIZE_WORDS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          mem_en,
  output logic [WE_WIDTH-1:0]           mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          busy
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int DEPTH = READ_LATENCY + 1;

  arb_state_t state, state_nxt;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         winner;
  logic                  any_req;
  logic                  grant;
  logic                  rd_grant;
  logic [ADDR_WIDTH-1:0] local_addr;
  logic [DEPTH-1:0]      pipe_vld;
  logic [IW-1:0]         pipe_idx [DEPTH];
  logic [DATA_WIDTH-1:0] rsp_data_q;

  dmem_port_arbiter_rr_grant #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_grant (
    .req         (req_valid),
    .ptr         (ptr),
    .winner      (winner),
    .grant_valid (any_req)
  );

  // reset is active-low: no grant can leak out while it is asserted.
  assign grant    = reset && (state == RUN) && !flush_req && any_req;
  assign rd_grant = grant && !req_write[winner];

  assign local_addr = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];

  generate
    if (PARTITION_EN) begin : g_part
      assign mem_addr = PARTITION_BASE
                      + ADDR_WIDTH'(winner) * ADDR_WIDTH'(PARTITION_WORDS)
                      + local_addr;
    end else begin : g_flat
      assign mem_addr = local_addr;
    end
  endgenerate

  assign mem_en    = grant;
  assign mem_we    = (grant && req_write[winner]) ? {WE_WIDTH{1'b1}} : '0;
  assign mem_din   = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  // Last pipeline stage is the response cycle; the stage before it lines up with valid mem_dout.
  assign rsp_valid = pipe_vld[DEPTH-1] ? (NUM_REQ'(1) << pipe_idx[DEPTH-1]) : '0;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|pipe_vld) | mem_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      pipe_vld   <= '0;
      rsp_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[DEPTH-2:0], rd_grant};
      pipe_idx[0] <= winner;
      for (int i = 1; i < DEPTH; i++) pipe_idx[i] <= pipe_idx[i-1];
      if (grant) ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
      if (pipe_vld[DEPTH-2]) rsp_data_q <= mem_dout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Leaving DRAIN looks at the stages that will still be occupied next cycle,
  // so flush_done rises right after the final response.
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        if (flush_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!flush_req)                 state_nxt = RUN;
        else if (pipe_vld[DEPTH-2:0] == '0) state_nxt = FLUSHED;
      end
      FLUSHED: begin
        flush_done = 1'b1;
        if (!flush_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule
